fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
- Next-generation synchronous single-clock FIFO. Generalises the existing FIFO with:
  - non-power-of-2 depth;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - fill-level output and programmable almost-full/almost-empty thresholds;
  - write-through-when-full on simultaneous read.
- Used as the common buffering primitive between streaming datapath stages.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2, any integer, not restricted to power of 2).
- AFULL_TH, DEPTH-2, almost_full asserts when level >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 2, almost_empty asserts when level <= AEMPTY_TH (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  write request.
- din  input  WIDTH  write data.
- rd_en  input  1  read request (FWFT: pop/acknowledge of the head word).
- dout  output  WIDTH  read data.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- almost_full  output  1  level >= AFULL_TH.
- almost_empty  output  1  level <= AEMPTY_TH.
- level  output  $clog2(DEPTH+1)  current occupancy.
- err_clr  input  1  clears sticky error flags (optional feature).
- overflow  output  1  sticky: write attempted and rejected.
- underflow  output  1  sticky: read attempted and rejected.

Behaviour:
- Reset: rst is synchronous and active-high. While rst is sampled high at a clk edge:
  - wr_ptr = rd_ptr = 0, level = 0;
  - dout = 0, overflow = underflow = 0;
  - resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data within that same edge.
- Accept rules:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_en). When full, a simultaneous read frees a slot, so the write is accepted.
  - When empty and both are asserted: write accepted, read rejected (no bypass).
- Pointers:
  - Each pointer increments by 1 on accept.
  - Wraps from DEPTH-1 to 0 by explicit compare, not modulo on a power of 2.
  - Pointer width is $clog2(DEPTH).
- Level:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Flags: full, empty, almost_full and almost_empty are combinational from the registered level, so they change in the same cycle level changes.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr], valid on the cycle after the edge (1-cycle latency).
  - dout holds its value otherwise.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] continuously; valid whenever !empty.
  - rd_acc advances to the next word.
  - A word written into an empty FIFO appears on dout the cycle after the write edge.
  - dout is don't-care while empty.
- Write-to-read latency: a word written at edge N is readable (rd_acc possible) at edge N+1.

Optional Feature:
- Macro: FIFO_FLEX_ERR_FLAGS_EN.
- Defined:
  - overflow sets on wr_en && !wr_acc; underflow sets on rd_en && !rd_acc.
  - Both are sticky until err_clr or rst. err_clr clears them at the next edge.
  - A set event and err_clr in the same cycle: set wins.
  - Rejected operations never alter storage, pointers or level.
- Not defined: overflow and underflow tied to 0, err_clr ignored. Ports remain present so the interface is stable.

Decomposition:
- Shared package fifo_pkg:
  - function ptr_w(depth) returning max(1, $clog2(depth));
  - function lvl_w(depth) returning $clog2(depth+1);
  - localparam defaults for WIDTH and DEPTH.
- One sub-module fifo_flex_mem:
  - DEPTH x WIDTH array, one write port;
  - read port selectable as registered or combinational via parameter;
  - no reset on the array.
- Pointer, level, flag and error logic live in fifo_flex.

Test Plan:
- DEPTH=5, FWFT=0: write 0x11..0x15 -> full=1, level=5; then 5 reads -> dout 0x11..0x15 each one cycle after its rd_en edge; empty=1, and pointers wrap through 4 -> 0.
- DEPTH=5, full, wr_en=rd_en=1 with din=0xAA -> level stays 5, dout=0x11, and 0xAA is read out last after 0x12..0x15.
- Empty, wr_en=rd_en=1 with din=0x3C -> write accepted, level=1, underflow=1 (with macro); in FWFT mode dout=0x3C next cycle.
- DEPTH=16, AFULL_TH=14, AEMPTY_TH=2: fill one word per cycle ->
  - almost_empty deasserts at level 3;
  - almost_full asserts at level 14;
  - full asserts at level 16.
- Level=7, assert rst for 1 cycle with wr_en=1 -> next cycle level=0, empty=1, dout=0, overflow=underflow=0.
- With macro: write while full and rd_en=0 -> overflow=1, level unchanged. Assert err_clr -> overflow=0 next cycle. Overflow event together with err_clr -> overflow stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameters for the fifo_flex family.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Pointer width; a depth of 1 would give $clog2 == 0, so keep at least one bit.
    function automatic int ptr_w(input int depth);
        return ($clog2(depth) > 1) ? $clog2(depth) : 1;
    endfunction

    // Level must be able to represent DEPTH itself, hence depth+1.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// Storage array for fifo_flex: DEPTH x WIDTH, one write port, one read port.
// Latency: REG_RD=1 -> read data one cycle after re; REG_RD=0 -> combinational.
// Backpressure: none; the caller guarantees addresses are in range.
// Ports: clk, rst (resets only the read register), we/waddr/wdata write port,
//        re/raddr read port, rdata read data.
module fifo_flex_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter bit REG_RD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // The array itself is intentionally not reset.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_RD) begin : g_reg_rd
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata <= '0;
            end else if (re) begin
                rdata <= mem[raddr];
            end
        end
    end else begin : g_comb_rd
        logic unused_rd;
        assign unused_rd = rst ^ re;
        assign rdata     = mem[raddr];
    end

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO: any depth >= 2, standard or FWFT read, level and threshold flags.
// Latency: write visible to read one edge later; standard dout one cycle after rd_en.
// Backpressure: writes rejected when full unless a read frees the slot in the same cycle.
// Ports: clk, rst (sync, active-high), wr_en/din write side, rd_en/dout read side,
//        full/empty/almost_full/almost_empty/level status, err_clr/overflow/underflow errors.
// Optional: define FIFO_FLEX_ERR_FLAGS_EN for sticky overflow/underflow flags.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          din,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [lvl_w(DEPTH)-1:0]   level,
    input  logic                      err_clr,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Flags are decoded straight from the registered level.
    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AFULL_TH));
    assign almost_empty = (level <= LW'(AEMPTY_TH));

    // When full, a concurrent read frees the slot the write lands in
    // (wr_ptr == rd_ptr); the old word is read before it is overwritten.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    fifo_flex_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (PW),
        .REG_RD (!FWFT)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // In FWFT the head word is shown directly; force zero while empty so
    // stale memory contents never leak out after reset.
    if (FWFT) begin : g_fwft
        assign dout = empty ? '0 : mem_rdata;
    end else begin : g_std
        assign dout = mem_rdata;
    end

`ifdef FIFO_FLEX_ERR_FLAGS_EN
    // Set has priority over clear so a same-cycle event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: three instances (5-deep standard, 5-deep FWFT,
// 16-deep with thresholds 14/2) share one stimulus set; each phase checks the
// instance it targets against hand-computed values.
module tb_fifo_flex;

`ifdef FIFO_FLEX_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       err_clr;

    logic [7:0] a_dout, b_dout, c_dout;
    logic       a_full, b_full, c_full;
    logic       a_empty, b_empty, c_empty;
    logic       a_af, b_af, c_af;
    logic       a_ae, b_ae, c_ae;
    logic [2:0] a_level, b_level;
    logic [4:0] c_level;
    logic       a_ovf, b_ovf, c_ovf;
    logic       a_unf, b_unf, c_unf;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(a_dout),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .level(a_level), .err_clr(err_clr), .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(b_dout),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .level(b_level), .err_clr(err_clr), .overflow(b_ovf), .underflow(b_unf)
    );

    fifo_flex #(.WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b0)) u_big (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(c_dout),
        .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
        .level(c_level), .err_clr(err_clr), .overflow(c_ovf), .underflow(c_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        din   = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; din = 8'h00; rd_en = 1'b0; err_clr = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_level", a_level, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full",  a_full,  0);
        check("rst_ae",    a_ae,    1);
        check("rst_af",    a_af,    0);
        check("rst_dout",  a_dout,  0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_unf",   a_unf,   0);

        // Fill 5-deep with 0x11..0x15
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        check("fill_full",  a_full,  1);
        check("fill_level", a_level, 5);
        check("fill_af",    a_af,    1);

        // Drain: standard dout one cycle after rd_en; FWFT head visible before pop
        for (int i = 0; i < 5; i++) begin
            check("fwft_head", b_dout, 8'h11 + 8'(i));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check("std_rd", a_dout, 8'h11 + 8'(i));
        end
        check("drain_empty", a_empty, 1);
        check("drain_level", a_level, 0);
        check("drain_unf",   a_unf,   0);

        // Refill after pointer wrap, then write-through on full
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hAA;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("wt_level", a_level, 5);
        check("wt_dout",  a_dout,  8'h11);
        check("wt_full",  a_full,  1);
        check("wt_ovf",   a_ovf,   0);
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check("wt_rd", a_dout, (i < 4) ? 8'h12 + 8'(i) : 8'hAA);
        end
        check("wt_empty", a_empty, 1);

        // Empty with simultaneous read and write: write only
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h3C;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("ew_level",  a_level, 1);
        check("ew_unf",    a_unf,   ERR_EN);
        check("ew_fwft",   b_dout,  8'h3C);
        check("ew_flevel", b_level, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("ew_rd",    a_dout,  8'h3C);
        check("ew_empty", a_empty, 1);

        // Overflow and err_clr behaviour
        do_reset();
        check("rst2_unf", a_unf, 0);
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        push(8'h77);
        check("ovf_level", a_level, 5);
        check("ovf_set",   a_ovf,   ERR_EN);
        check("ovf_head",  b_dout,  8'h11);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", a_ovf, 0);
        wr_en = 1'b1; err_clr = 1'b1; din = 8'h78;
        tick();
        wr_en = 1'b0; err_clr = 1'b0;
        check("ovf_win",    a_ovf,   ERR_EN);
        check("ovf_level2", a_level, 5);

        // Threshold walk on the 16-deep instance
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            check("thr_level", c_level, i);
            check("thr_ae",    c_ae,    (i <= 2)  ? 1 : 0);
            check("thr_af",    c_af,    (i >= 14) ? 1 : 0);
            check("thr_full",  c_full,  (i == 16) ? 1 : 0);
        end

        // Reset mid-operation with wr_en held high
        do_reset();
        push(8'h01);
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h02;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 3; i <= 8; i++) push(8'(i));
        check("mid_level", c_level, 7);
        check("mid_dout",  a_dout,  8'h01);
        check("mid_ovf",   a_ovf,   ERR_EN);
        rst = 1'b1; wr_en = 1'b1; din = 8'hEE;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check("mr_level", c_level, 0);
        check("mr_empty", c_empty, 1);
        check("mr_ae",    c_ae,    1);
        check("mr_af",    c_af,    0);
        check("mr_dout",  a_dout,  0);
        check("mr_ovf",   a_ovf,   0);
        check("mr_unf",   a_unf,   0);
        check("mr_alvl",  a_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
